// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the all-ones quotient returned on divide by zero.
package seq_divider16_pkg;

    localparam int N_DEF     = 16;
    localparam int CNT_W_DEF = $clog2(N_DEF) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N_DEF-1:0] ALL_ONES = '1;

endpackage

// File: rtl/seq_divider16_if.sv
// Operand/result handshake bundle between the ALU issue stage and the divider.
interface seq_divider16_if
    import seq_divider16_pkg::*;
#(
    parameter int N = N_DEF
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider16_sub_cla.sv
// W-bit subtractor a - b computed as a + ~b + 1 with 4-bit carry-look-ahead
// groups chained by their group carry; any bits above the last full group ripple.
module seq_divider16_sub_cla #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int NG = W / 4;

    logic [W-1:0] bn;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign bn   = ~b;
    assign p    = a ^ bn;
    assign g    = a & bn;
    assign c[0] = 1'b1;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    for (genvar i = NG * 4; i < W; i++) begin : g_tail
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign diff   = p ^ c[W-1:0];
    assign borrow = ~c[W];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock,
// single operation in flight behind a valid/ready handshake on each side.
module seq_divider16
    import seq_divider16_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_divider16_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     r_q, r_d;
    logic [N-1:0]     dv_q, dv_d;
    logic             dz_q, dz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [N:0]       trial;
    logic             borrow;
    logic             take;

    seq_divider16_sub_cla #(.W(N + 1)) u_sub (
        .a      ({r_q, q_q[N-1]}),
        .b      ({1'b0, dv_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // With R < D held as an invariant, a borrow-free trial always has a clear MSB.
    assign take = ~(borrow | trial[N]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        r_d         = r_q;
        dv_d        = dv_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    dv_d       = bus.divisor;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (bus.divisor == '0) begin
                        q_d         = {N{1'b1}};
                        r_d         = bus.dividend;
                        dz_d        = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        q_d     = bus.dividend;
                        r_d     = '0;
                        dz_d    = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (take) begin
                    r_d = trial[N-1:0];
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = {r_q[N-2:0], q_q[N-1]};
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dv_q        <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dv_q        <= dv_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed vector table, backpressure and mid-operation reset sequences, then a
// randomized back-to-back stream scored against the language / and % operators.
module tb_seq_divider16;
    import seq_divider16_pkg::*;

    localparam int N      = 16;
    localparam int N_RAND = 2500;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider16_if #(.N(N)) bus ();

    seq_divider16 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } rsp_t;

    vec_t vecs[11];
    rsp_t exp_q[$];

    // Called at a negedge; returns at the negedge after the result was drained.
    task automatic run_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic dz, output int lat, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        bus.out_ready = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = ok && bus.out_valid && (n < 100);
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_by_zero;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] q, r, pd, ps;
        logic         dz, ok, pending, bad;
        int           lat, n, issued, received, cyc;
        rsp_t         e, got;

        vecs[0]  = '{16'd100,  16'd7,      16'd14,     16'd2,      1'b0, 17};
        vecs[1]  = '{16'hFFFF, 16'h0001,   16'hFFFF,   16'h0000,   1'b0, 17};
        vecs[2]  = '{16'hFFFF, 16'hFFFF,   16'h0001,   16'h0000,   1'b0, 17};
        vecs[3]  = '{16'd5,    16'd9,      16'd0,      16'd5,      1'b0, 17};
        vecs[4]  = '{16'h1234, 16'h0000,   ALL_ONES,   16'h1234,   1'b1, 1};
        vecs[5]  = '{16'd0,    16'd5,      16'd0,      16'd0,      1'b0, 17};
        vecs[6]  = '{16'd1000, 16'd3,      16'd333,    16'd1,      1'b0, 17};
        vecs[7]  = '{16'h8000, 16'h0003,   16'h2AAA,   16'h0002,   1'b0, 17};
        vecs[8]  = '{16'hFFFF, 16'h0100,   16'h00FF,   16'h00FF,   1'b0, 17};
        vecs[9]  = '{16'd7,    16'd7,      16'd1,      16'd0,      1'b0, 17};
        vecs[10] = '{16'd0,    16'd0,      ALL_ONES,   16'd0,      1'b1, 1};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),    64'(1));
        check("rst_out_valid", 64'(bus.out_valid),   64'(0));
        check("rst_quotient",  64'(bus.quotient),    64'(0));
        check("rst_remainder", 64'(bus.remainder),   64'(0));
        check("rst_dz",        64'(bus.div_by_zero), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, q, r, dz, lat, ok);
            check($sformatf("v%0d_done", i), 64'(ok),  64'(1));
            check($sformatf("v%0d_q",    i), 64'(q),   64'(vecs[i].q));
            check($sformatf("v%0d_r",    i), 64'(r),   64'(vecs[i].r));
            check($sformatf("v%0d_dz",   i), 64'(dz),  64'(vecs[i].dz));
            check($sformatf("v%0d_lat",  i), 64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure: stall DONE for 20 cycles while offering a competing operation.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'd100;
        bus.divisor   = 16'd7;
        @(negedge clk);
        bus.dividend  = 16'hBEEF;
        bus.divisor   = 16'd3;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", 64'(bus.out_valid), 64'(1));
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2 || bus.div_by_zero !== 1'b0
                || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                bad = 1'b1;
            @(negedge clk);
        end
        check("bp_stable", 64'(bad), 64'(0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready",  64'(bus.in_ready),  64'(1));
        check("bp_release_out_valid", 64'(bus.out_valid), 64'(0));

        // Reset after 8 iterations of 1000/3.
        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", 64'(bus.in_ready), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready",  64'(bus.in_ready),    64'(1));
        check("mid_rst_out_valid", 64'(bus.out_valid),   64'(0));
        check("mid_rst_q",         64'(bus.quotient),    64'(0));
        check("mid_rst_r",         64'(bus.remainder),   64'(0));
        check("mid_rst_dz",        64'(bus.div_by_zero), 64'(0));
        @(negedge clk);
        run_op(16'd1000, 16'd3, q, r, dz, lat, ok);
        check("rerun_done", 64'(ok),  64'(1));
        check("rerun_q",    64'(q),   64'(333));
        check("rerun_r",    64'(r),   64'(1));
        check("rerun_lat",  64'(lat), 64'(17));

        // Random stream: decide inputs at each negedge, predict the upcoming edge's handshakes.
        pending  = 1'b0;
        issued   = 0;
        received = 0;
        cyc      = 0;
        pd       = '0;
        ps       = '0;
        while ((issued < N_RAND || exp_q.size() > 0) && cyc < 90000) begin
            if (!pending && issued < N_RAND && $urandom_range(3) != 0) begin
                pd = 16'($urandom);
                case ($urandom_range(7))
                    0:       ps = '0;
                    1:       ps = 16'($urandom_range(15, 1));
                    2:       pd = 16'($urandom_range(255));
                    default: ps = 16'($urandom);
                endcase
                if ($urandom_range(7) == 2) ps = 16'($urandom_range(65535, 1));
                pending = 1'b1;
            end
            bus.in_valid  = pending;
            bus.dividend  = pending ? pd : 16'($urandom);
            bus.divisor   = pending ? ps : 16'($urandom);
            bus.out_ready = 1'($urandom_range(1));
            if (bus.in_valid && bus.in_ready) begin
                if (ps == '0) e = '{ALL_ONES, pd, 1'b1};
                else          e = '{pd / ps, pd % ps, 1'b0};
                exp_q.push_back(e);
                pending = 1'b0;
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("rand_in_flight", 64'(exp_q.size()), 64'(1));
                if (exp_q.size() > 0) begin
                    e   = exp_q.pop_front();
                    got = '{bus.quotient, bus.remainder, bus.div_by_zero};
                    check($sformatf("rand_%0d", received), 64'({got.q, got.r, got.dz}),
                          64'({e.q, e.r, e.dz}));
                end
                received++;
            end
            @(negedge clk);
            cyc++;
        end
        check("rand_issued",   64'(issued),       64'(N_RAND));
        check("rand_received", 64'(received),     64'(N_RAND));
        check("rand_leftover", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
